// File: rtl/sum_loop_checker_pkg.sv
// Shared types for the i/j/k/n accumulation-loop checker: data width, checker states,
// the observed loop vector and the termination-time safety predicate.
package sum_loop_pkg;

  localparam int W = 13;

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    INIT = 3'd1,
    RUN  = 3'd2,
    DONE = 3'd3,
    FAIL = 3'd4
  } chk_state_t;

  typedef struct packed {
    logic [W-1:0] i;
    logic [W-1:0] j;
    logic [W-1:0] k;
    logic [W-1:0] n;
  } loop_vec_t;

  // True when the safety property is violated: 2n >= k+j+i, evaluated without overflow.
  function automatic logic prop_fails(input loop_vec_t v);
    logic [W:0]   lhs;
    logic [W+1:0] rhs;
    lhs = {v.n, 1'b0};
    rhs = {2'b00, v.k} + {2'b00, v.j} + {2'b00, v.i};
    return ({1'b0, lhs} >= rhs);
  endfunction

endpackage

// File: rtl/sum_loop_checker_if.sv
// Observation bus carrying the loop's i/j/k/n outputs into the checker.
interface sum_loop_checker_if;
  import sum_loop_pkg::*;

  logic [W-1:0] i_in;
  logic [W-1:0] j_in;
  logic [W-1:0] k_in;
  logic [W-1:0] n_in;

  modport master (output i_in, j_in, k_in, n_in);
  modport slave  (input  i_in, j_in, k_in, n_in);

endinterface

// File: rtl/sum_loop_step_model.sv
// Combinational one-step model of the loop: while i<=n advance i and accumulate j, else hold.
module sum_loop_step_model
  import sum_loop_pkg::*;
(
  input  loop_vec_t cur,
  output loop_vec_t nxt
);

  always_comb begin
    nxt = cur;
    if (cur.i <= cur.n) begin
      nxt.i = cur.i + 1'b1;
      nxt.j = cur.j + cur.i;
    end
  end

endmodule

// File: rtl/sum_loop_checker.sv
// Downstream monitor for the accumulation loop: checks reset values, every step against a
// shadow-driven model, termination with its safety property, and a RUN-cycle timeout.
module sum_loop_checker
  import sum_loop_pkg::*;
#(
  parameter int K_INIT  = 80,
  parameter int N_INIT  = 100,
  parameter int TIMEOUT = 200
) (
  input  logic               clk,
  input  logic               rst,
  sum_loop_checker_if.slave  obs,
  output logic               done,
  output logic               pass,
  output logic               err_init,
  output logic               err_step,
  output logic               err_prop,
  output logic               err_timeout,
  output logic [15:0]        cycle_cnt,
  output logic [15:0]        fail_cycle
);

  localparam logic [2:0] ST_IDLE = IDLE;
  localparam logic [2:0] ST_RUN  = RUN;
  localparam logic [2:0] ST_DONE = DONE;
  localparam logic [2:0] ST_FAIL = FAIL;

  localparam loop_vec_t INIT_VEC = '{i: '0, j: '0, k: W'(K_INIT), n: W'(N_INIT)};

  logic [2:0]  state;
  loop_vec_t   shadow;
  loop_vec_t   sample;
  loop_vec_t   exp_vec;
  logic [15:0] run_cnt;
  logic [15:0] run_next;
  logic [15:0] cycle_next;

  logic init_bad;
  logic step_bad;
  logic term;
  logic prop_bad;
  logic timeout_hit;
  logic run_err;
  logic any_err;

  assign sample = '{i: obs.i_in, j: obs.j_in, k: obs.k_in, n: obs.n_in};

  sum_loop_step_model u_model (
    .cur (shadow),
    .nxt (exp_vec)
  );

  assign run_next   = run_cnt + 16'd1;
  assign cycle_next = (cycle_cnt == 16'hFFFF) ? cycle_cnt : cycle_cnt + 16'd1;

  // A step error is judged before termination; a terminating sample never times out.
  assign init_bad    = (sample != INIT_VEC);
  assign step_bad    = (sample != exp_vec);
  assign term        = (sample.i > sample.n);
  assign prop_bad    = term && prop_fails(sample);
  assign timeout_hit = (TIMEOUT != 0) && !term && !step_bad && (run_next == 16'(TIMEOUT));
  assign run_err     = step_bad || prop_bad || timeout_hit;
  assign any_err     = err_init | err_step | err_prop | err_timeout;

  assign pass = done & ~any_err;

  // The first post-reset sample is the init sample, so the init comparison happens on the
  // edge that leaves IDLE and the shadow is loaded from it at the same time.
  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= ST_IDLE;
      shadow      <= '0;
      run_cnt     <= '0;
      cycle_cnt   <= '0;
      fail_cycle  <= '0;
      done        <= 1'b0;
      err_init    <= 1'b0;
      err_step    <= 1'b0;
      err_prop    <= 1'b0;
      err_timeout <= 1'b0;
    end else begin
      cycle_cnt <= cycle_next;
      case (state)
        ST_IDLE: begin
          shadow  <= sample;
          run_cnt <= '0;
          if (init_bad) begin
            err_init   <= 1'b1;
            fail_cycle <= cycle_next;
            state      <= ST_FAIL;
          end else begin
            state <= ST_RUN;
          end
        end
        ST_RUN: begin
          shadow  <= sample;
          run_cnt <= run_next;
          if (step_bad)    err_step    <= 1'b1;
          if (term)        done        <= 1'b1;
          if (prop_bad)    err_prop    <= 1'b1;
          if (timeout_hit) err_timeout <= 1'b1;
          if (run_err) begin
            state <= ST_FAIL;
            if (!any_err) fail_cycle <= cycle_next;
          end else if (term) begin
            state <= ST_DONE;
          end
        end
        default: ;
      endcase
    end
  end

endmodule
